// File: rtl/truth_table_sweeper.sv
// Sweeps the 4-bit code driving a combinational function block, captures each
// 10-bit result row into a small truth-table RAM and folds it into an XOR signature.
module truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       w,
    output logic       x,
    output logic       y,
    output logic       z,
    input  logic [9:0] f_in,
    output logic       busy,
    output logic       done,
    input  logic [3:0] rd_addr,
    output logic [9:0] rd_data,
    output logic [9:0] signature
);

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] code;
    logic [7:0] counter;
    logic [9:0] mem [16];

    logic launch;
    logic do_write;
    logic advance;
    logic clear_code;

    assign {w, x, y, z} = code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // abort outranks start, and a CAPTURE cycle hit by abort never writes
    always_comb begin
        state_nxt  = state;
        launch     = 1'b0;
        do_write   = 1'b0;
        advance    = 1'b0;
        clear_code = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = SETTLE;
                    launch    = 1'b1;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt  = IDLE;
                    clear_code = 1'b1;
                end else if (counter == 8'd0) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt  = IDLE;
                    clear_code = 1'b1;
                end else begin
                    do_write = 1'b1;
                    if (code == 4'd15) begin
                        state_nxt = DONE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = SETTLE;
                    end
                end
            end
            DONE: begin
                done = 1'b1;
                if (abort) begin
                    state_nxt  = IDLE;
                    clear_code = 1'b1;
                end else if (start) begin
                    state_nxt = SETTLE;
                    launch    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code      <= 4'd0;
            counter   <= 8'd0;
            signature <= 10'd0;
        end else begin
            if (launch) begin
                code      <= 4'd0;
                counter   <= RELOAD;
                signature <= 10'd0;
            end else begin
                if (clear_code) begin
                    code <= 4'd0;
                end else if (advance) begin
                    code    <= code + 4'd1;
                    counter <= RELOAD;
                end else if (state == SETTLE && counter != 8'd0) begin
                    counter <= counter - 8'd1;
                end
                if (do_write) begin
                    signature <= signature ^ f_in;
                end
            end
        end
    end

    // Read is registered from the pre-edge contents, so a same-edge write is not visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= 10'd0;
            end
            rd_data <= 10'd0;
        end else begin
            rd_data <= mem[rd_addr];
            if (do_write) begin
                mem[code] <= f_in;
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: behavioural sweep model checked every cycle,
// plus directed latency/row/signature expectations; a second instance uses SETTLE_CYCLES=3.
module tb_truth_table_sweeper;

    localparam int S  = 4;
    localparam int S3 = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       w, x, y, z;
    logic [9:0] f_in;
    logic       busy;
    logic       done;
    logic [3:0] rd_addr;
    logic [9:0] rd_data;
    logic [9:0] signature;

    logic       start3;
    logic       abort3;
    logic       w3, x3, y3, z3;
    logic [9:0] f3;
    logic       busy3;
    logic       done3;
    logic [3:0] rd_addr3;
    logic [9:0] rd_data3;
    logic [9:0] sig3;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    int         mode;
    logic [9:0] tab [16];

    always #5 clk = ~clk;

    truth_table_sweeper #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .w(w), .x(x), .y(y), .z(z), .f_in(f_in),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
        .signature(signature)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(S3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
        .w(w3), .x(x3), .y(y3), .z(z3), .f_in(f3),
        .busy(busy3), .done(done3), .rd_addr(rd_addr3), .rd_data(rd_data3),
        .signature(sig3)
    );

    // Function block stand-in: output depends only on the presented code
    function automatic logic [9:0] fblk(input int md, input logic [3:0] c, input logic [9:0] t);
        case (md)
            0:       return {6'b0, c};
            2:       return (c == 4'd5) ? 10'h005 : 10'h000;
            3:       return 10'h3FF;
            4:       return t;
            default: return 10'h000;
        endcase
    endfunction

    assign f_in = fblk(mode, {w, x, y, z}, tab[{w, x, y, z}]);

    // Stale block for the second instance: garbage for ~2 cycles after each code change
    logic [3:0] prev3 = 4'd0;
    int         age3  = 100;
    always @(negedge clk) begin
        if ({w3, x3, y3, z3} != prev3) begin
            prev3 = {w3, x3, y3, z3};
            age3  = 0;
        end else if (age3 < 100) begin
            age3++;
        end
    end
    assign f3 = (age3 < 2) ? 10'h2AA : {6'b0, w3, x3, y3, z3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a sweep is a timeline of 16 slots of S+1 cycles each
    bit         m_active;
    bit         m_done;
    int         m_t;
    logic [3:0] m_code;
    logic [9:0] m_mem [16];
    logic [9:0] m_sig;
    logic [9:0] m_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_t      = 0;
            m_code   = 4'd0;
            m_sig    = 10'd0;
            m_rd     = 10'd0;
            for (int i = 0; i < 16; i++) m_mem[i] = 10'd0;
        end else begin
            m_rd = m_mem[rd_addr];
            if (m_active) begin
                if (abort) begin
                    m_active = 1'b0;
                    m_code   = 4'd0;
                end else begin
                    if (m_t % (S + 1) == S) begin
                        logic [9:0] fe;
                        fe = fblk(mode, m_code, tab[m_code]);
                        m_mem[m_code] = fe;
                        m_sig = m_sig ^ fe;
                        if (m_code == 4'd15) begin
                            m_active = 1'b0;
                            m_done   = 1'b1;
                        end
                    end
                    if (m_active) begin
                        m_t++;
                        m_code = 4'(m_t / (S + 1));
                    end
                end
            end else if (abort) begin
                m_done = 1'b0;
                m_code = 4'd0;
            end else if (start) begin
                m_active = 1'b1;
                m_done   = 1'b0;
                m_t      = 0;
                m_code   = 4'd0;
                m_sig    = 10'd0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_on) begin
            chk("wxyz", 32'({w, x, y, z}), 32'(m_code));
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(m_done));
            chk("signature", 32'(signature), 32'(m_sig));
            chk("rd_data", 32'(rd_data), 32'(m_rd));
        end
    end

    task automatic read_row(input logic [3:0] k, output logic [9:0] v);
        @(negedge clk);
        rd_addr = k;
        @(posedge clk);
        #1;
        v = rd_data;
    endtask

    task automatic launch_sweep();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
    endtask

    initial begin
        int         n;
        logic [9:0] v;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0; rd_addr = 4'd0;
        start3 = 1'b0; abort3 = 1'b0; rd_addr3 = 4'd0;
        for (int i = 0; i < 16; i++) tab[i] = 10'd0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        cmp_on = 1'b1;

        // Reset in the middle of a sweep
        launch_sweep();
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wxyz", 32'({w, x, y, z}), 32'd0);
        chk("rst_sig", 32'(signature), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            read_row(4'(k), v);
            chk("rst_row", 32'(v), 32'd0);
        end

        // Identity function
        mode = 0;
        launch_sweep();
        wait_done(n);
        chk("ident_latency", 32'(n), 32'd80);
        chk("ident_sig", 32'(signature), 32'd0);
        chk("ident_model_sig", 32'(m_sig), 32'd0);
        for (int k = 0; k < 16; k++) begin
            read_row(4'(k), v);
            chk("ident_row", 32'(v), 32'(k));
        end

        // Single non-zero row
        mode = 2;
        launch_sweep();
        wait_done(n);
        chk("sparse_latency", 32'(n), 32'd80);
        chk("sparse_sig", 32'(signature), 32'h005);
        for (int k = 0; k < 16; k++) begin
            read_row(4'(k), v);
            chk("sparse_row", 32'(v), (k == 5) ? 32'h005 : 32'h000);
        end

        // Abort on the third SETTLE cycle of code 7
        mode = 4;
        for (int i = 0; i < 16; i++) tab[i] = 10'($urandom_range(1, 1023));
        launch_sweep();
        repeat (37) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_wxyz", 32'({w, x, y, z}), 32'd0);
        for (int k = 0; k < 8; k++) begin
            read_row(4'(k), v);
            chk("abort_row", 32'(v), (k == 7) ? 32'h000 : 32'(tab[k]));
        end

        // start and abort together in IDLE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("startabort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("startabort_busy2", 32'(busy), 32'd0);

        // start while busy is ignored; latency still counts from the first start
        for (int i = 0; i < 16; i++) tab[i] = 10'($urandom);
        launch_sweep();
        repeat (20) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 21;
        while (n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
        chk("busy_start_latency", 32'(n), 32'd80);

        // restart straight from DONE
        mode = 3;
        launch_sweep();
        chk("restart_sig_clear", 32'(signature), 32'd0);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        wait_done(n);
        chk("restart_latency", 32'(n), 32'd80);
        chk("restart_sig", 32'(signature), 32'd0);
        for (int k = 0; k < 16; k++) begin
            read_row(4'(k), v);
            chk("restart_row", 32'(v), 32'h3FF);
        end

        // Random start/abort/read traffic with random row contents
        mode = 4;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rd_addr = 4'($urandom);
            start   = ($urandom_range(0, 19) == 0);
            abort   = ($urandom_range(0, 99) == 0);
            if (!busy && $urandom_range(0, 3) == 0) tab[$urandom_range(0, 15)] = 10'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;

        // Second instance: SETTLE_CYCLES=3 with a block that settles after 2 cycles
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (done3) break;
        end
        chk("s3_latency", 32'(n), 32'd64);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            rd_addr3 = 4'(k);
            @(posedge clk);
            #1;
            chk("s3_row", 32'(rd_data3), 32'(k));
        end
        chk("s3_sig", 32'(sig3), 32'd0);

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencing stage wrapped around the 4-input / 10-output combinational function block of the ALU Part 1 logic.
- Upstream side: drives the block's w,x,y,z inputs through all 16 codes.
- Downstream side: samples the 10 function outputs (f0..f9) after a programmable settle time, stores one 10-bit row per code in an internal truth-table RAM, and accumulates an XOR signature.
- Provides hardware self-characterisation of the logic block; replaces the testbench-only #60 sweep.

Parameters:
SETTLE_CYCLES, 4, clock cycles the code is held before sampling f_in; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; sampled only in IDLE or DONE
abort  input  1  synchronous abort; returns to IDLE from any busy state
w  output  1  code bit 3 to function block
x  output  1  code bit 2
y  output  1  code bit 1
z  output  1  code bit 0
f_in  input  10  function block outputs, f_in[k] = fk
busy  output  1  high in SETTLE or CAPTURE
done  output  1  high in DONE, held until next start or abort
rd_addr  input  4  truth-table read address (code)
rd_data  output  10  registered read data, mem[rd_addr]
signature  output  10  XOR of all rows captured in current/last sweep

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; code=0 (so w,x,y,z=0); counter=0.
  - busy=0, done=0, signature=0, rd_data=0, all 16 RAM rows=0.
  - Reset mid-sweep discards all progress.
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE or DONE, start=1 at an edge:
  - next state SETTLE; code=0; counter=SETTLE_CYCLES-1; signature cleared to 0.
  - done drops the same edge.
  - RAM is not cleared; every row is overwritten during the sweep.
- SETTLE:
  - {w,x,y,z}=code, held stable.
  - Counter decrements each cycle; at counter==0 next state is CAPTURE.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- CAPTURE (one cycle), at its closing edge:
  - mem[code]<=f_in; signature<=signature^f_in.
  - If code==15: next state DONE, code stays 15.
  - Else: code<=code+1, counter reloaded, next state SETTLE.
- Code does not wrap past 15 within a sweep.
- Latency: from the edge sampling start to DONE entry is 16*(SETTLE_CYCLES+1) cycles; 80 with default.
- DONE:
  - done=1, busy=0; outputs hold the last code (w,x,y,z=1111).
  - Remains until start (new sweep) or abort.
- abort:
  - In SETTLE or CAPTURE, abort=1 → IDLE next edge.
  - Rows captured before the aborted cycle persist. A CAPTURE cycle coinciding with abort does not write.
  - code<=0, done=0.
  - signature holds its partial value.
  - abort in IDLE has no effect; abort in DONE → IDLE.
- Simultaneous start and abort: abort wins.
- start while busy: ignored.
- Read port:
  - rd_data<=mem[rd_addr] every edge, 1-cycle latency, in all states.
  - Read of a row written the same edge returns the old value.
- busy=1 exactly in SETTLE and CAPTURE; busy and done never both high.

Test Plan:
- Reset mid-sweep: start, wait 30 cycles, pulse rst_n low → immediately busy=0, done=0, wxyz=0000, signature=0, every rd_data read returns 0.
- Identity sweep: bench drives f_in={6'b0,w,x,y,z}, start=1 one cycle → done rises exactly 80 cycles later; rd_addr=k returns 10'(k) for k=0..15; signature=0.
- Settle check: SETTLE_CYCLES=3, f_in from a model that is stale (10'h2AA) for the first 2 cycles after each code change, then correct → no row contains 10'h2AA; done after 64 cycles.
- Sparse signature: f_in=10'h005 only when code==5, else 0 → signature=10'h005; mem[5]=10'h005, all others 0.
- Abort: abort=1 on the 3rd cycle of code 7's SETTLE → IDLE next edge, done=0; rows 0..6 valid, row 7 unchanged; start+abort same cycle in IDLE → stays IDLE.
- Back-to-back: start during busy ignored; start in DONE with f_in=10'h3FF constant → new sweep, signature=0, all rows 10'h3FF.
